// File: rtl/mgmt_core_memtest_pkg.sv
// mgmt_core_memtest_pkg: checkpoint codes, SPI commands, FSM states and lane helpers
package mgmt_core_memtest_pkg;
  localparam logic [15:0] CP_A040 = 16'hA040;
  localparam logic [15:0] CP_AB40 = 16'hAB40;
  localparam logic [15:0] CP_AB41 = 16'hAB41;
  localparam logic [15:0] CP_A020 = 16'hA020;
  localparam logic [15:0] CP_AB20 = 16'hAB20;
  localparam logic [15:0] CP_AB21 = 16'hAB21;
  localparam logic [15:0] CP_A010 = 16'hA010;
  localparam logic [15:0] CP_AB10 = 16'hAB10;
  localparam logic [15:0] CP_AB11 = 16'hAB11;
  localparam logic [7:0] SPI_WAKE = 8'hAB;
  localparam logic [7:0] SPI_READ = 8'h03;
  typedef enum logic [3:0] {S_IDLE, S_FLASH, S_ENTER, S_WR, S_RD, S_CMP, S_PASS, S_HALT, S_DONE} state_t;
  function automatic logic [15:0] enter_code(logic [1:0] ph);
    return ph == 2'd0 ? CP_A040 : ph == 2'd1 ? CP_A020 : CP_A010;
  endfunction
  function automatic logic [15:0] pass_code(logic [1:0] ph);
    return ph == 2'd0 ? CP_AB41 : ph == 2'd1 ? CP_AB21 : CP_AB11;
  endfunction
  function automatic logic [15:0] fail_code(logic [1:0] ph);
    return ph == 2'd0 ? CP_AB40 : ph == 2'd1 ? CP_AB20 : CP_AB10;
  endfunction
  // item j packs {word, lane}; the lane field is 0, 1 or 2 bits wide for word/short/byte
  function automatic logic [3:0] lane_be(logic [15:0] j, logic [1:0] ph);
    return ph == 2'd0 ? 4'hF : ph == 2'd1 ? (j[0] ? 4'hC : 4'h3) : 4'b0001 << j[1:0];
  endfunction
  function automatic logic [31:0] lane_data(logic [31:0] seed, logic [15:0] j, logic [1:0] ph);
    return ph == 2'd0 ? seed + {16'b0, j} : ph == 2'd1 ? {2{seed[15:0] ^ j}} : {4{seed[7:0] + j[7:0]}};
  endfunction
endpackage

// File: rtl/mgmt_core_memtest_if.sv
// mgmt_core_memtest_if: SPI flash pins of the management core
interface mgmt_core_memtest_if;
  logic flash_csb;
  logic flash_clk;
  logic flash_io0_oeb;
  logic flash_io0_do;
  logic flash_io1_di;
  modport master(output flash_csb, flash_clk, flash_io0_oeb, flash_io0_do, input flash_io1_di);
  modport slave(input flash_csb, flash_clk, flash_io0_oeb, flash_io0_do, output flash_io1_di);
endinterface

// File: rtl/mgmt_core_memtest_reader.sv
// mgmt_flash_word_reader: SPI mode-0 wake (0xAB) then 4-byte read from address 0
module mgmt_flash_word_reader
  import mgmt_core_memtest_pkg::*;
(
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        start,
  output logic        done,
  output logic [31:0] seed,
  mgmt_core_memtest_if.master spi
);
  typedef enum logic [2:0] {R_IDLE, R_WAKE, R_GAP, R_READ, R_DONE} rstate_t;
  rstate_t st;
  logic [63:0] sh;
  logic [5:0] n;
  logic [1:0] g;
  logic [31:0] rx, rx_next;
  assign rx_next = {rx[30:0], spi.flash_io1_di};
  assign spi.flash_io0_oeb = 1'b0;
  // sh[63] is the next bit to drive; n counts bits still to send after the current one
  always_ff @(posedge core_clk)
    if (!core_rstn) begin
      st <= R_IDLE;
      sh <= '0;
      n <= '0;
      g <= '0;
      rx <= '0;
      done <= 1'b0;
      seed <= '0;
      spi.flash_csb <= 1'b1;
      spi.flash_clk <= 1'b0;
      spi.flash_io0_do <= 1'b0;
    end else case (st)
      R_IDLE: if (start) begin
        st <= R_WAKE;
        spi.flash_csb <= 1'b0;
        spi.flash_io0_do <= SPI_WAKE[7];
        sh <= {SPI_WAKE[6:0], 57'b0};
        n <= 6'd7;
      end
      R_WAKE, R_READ: if (!spi.flash_clk) spi.flash_clk <= 1'b1;
      else begin
        spi.flash_clk <= 1'b0;
        rx <= rx_next;
        if (n != 6'd0) begin
          n <= n - 6'd1;
          spi.flash_io0_do <= sh[63];
          sh <= {sh[62:0], 1'b0};
        end else begin
          spi.flash_csb <= 1'b1;
          spi.flash_io0_do <= 1'b0;
          g <= '0;
          st <= st == R_WAKE ? R_GAP : R_DONE;
          if (st == R_READ) begin
            done <= 1'b1;
            seed <= {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
          end
        end
      end
      R_GAP: if (g == 2'd3) begin
        st <= R_READ;
        spi.flash_csb <= 1'b0;
        spi.flash_io0_do <= SPI_READ[7];
        sh <= {SPI_READ[6:0], 57'b0};
        n <= 6'd63;
      end else g <= g + 2'd1;
      default: ;
    endcase
endmodule

// File: rtl/mgmt_core_memtest.sv
// mgmt_core_memtest: flash seed fetch then word/halfword/byte SRAM self-test with checkpoint codes
module mgmt_core_memtest
  import mgmt_core_memtest_pkg::*;
#(
  parameter int MEM_WORDS  = 512,
  parameter int TEST_WORDS = 16,
  parameter int FAULT_WORD = -1
) (
  input  logic         core_clk,
  input  logic         core_rstn,
  output logic         gpio_out_pad,
  output logic [127:0] la_output,
  mgmt_core_memtest_if.master spi,
  input  logic [31:0]  mprj_dat_i,
  input  logic         mprj_ack_i,
  input  logic [31:0]  hk_dat_i,
  input  logic         hk_ack_i
);
  localparam int AW = $clog2(MEM_WORDS);
  state_t st;
  logic [1:0] ph;
  logic [15:0] code, j;
  logic h, start, done, last, fault, mismatch, unused;
  logic [31:0] seed, rdata, wdata, bmask;
  logic [31:0] mem [MEM_WORDS];
  logic [3:0] be;
  logic [AW-1:0] addr, ra;
  assign unused = ^{mprj_dat_i, mprj_ack_i, hk_dat_i, hk_ack_i};
  assign addr = AW'(j >> ph);
  assign be = lane_be(j, ph);
  assign wdata = lane_data(seed, j, ph);
  assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign last = j == 16'((TEST_WORDS << ph) - 1);
  assign fault = FAULT_WORD >= 0 && int'(ra) == FAULT_WORD;
  assign mismatch = ((rdata ^ {31'b0, fault}) & bmask) != (wdata & bmask);
  assign la_output = {96'b0, code, j};
  mgmt_flash_word_reader u_rd (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .start    (start),
    .done     (done),
    .seed     (seed),
    .spi      (spi)
  );
  always_ff @(posedge core_clk) begin
    if (st == S_WR)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    rdata <= mem[addr];
    ra <= addr;
  end
  // S_PASS lasts two cycles so every pass code is visible for at least two cycles
  always_ff @(posedge core_clk)
    if (!core_rstn) begin
      st <= S_IDLE;
      ph <= '0;
      code <= '0;
      j <= '0;
      h <= 1'b0;
      start <= 1'b0;
      gpio_out_pad <= 1'b0;
    end else case (st)
      S_IDLE: begin
        start <= 1'b1;
        st <= S_FLASH;
      end
      S_FLASH: begin
        start <= 1'b0;
        if (done) begin
          code <= enter_code(ph);
          st <= S_ENTER;
        end
      end
      S_ENTER: st <= S_WR;
      S_WR: if (last) begin
        j <= '0;
        st <= S_RD;
      end else j <= j + 16'd1;
      S_RD: st <= S_CMP;
      S_CMP: if (mismatch) begin
        code <= fail_code(ph);
        st <= S_HALT;
      end else if (last) begin
        code <= pass_code(ph);
        h <= 1'b0;
        st <= S_PASS;
      end else begin
        j <= j + 16'd1;
        st <= S_RD;
      end
      S_PASS: if (!h) h <= 1'b1;
      else if (ph == 2'd2) begin
        gpio_out_pad <= 1'b1;
        st <= S_DONE;
      end else begin
        ph <= ph + 2'd1;
        code <= enter_code(ph + 2'd1);
        j <= '0;
        st <= S_ENTER;
      end
      default: ;
    endcase
endmodule

// File: tb/tb_mgmt_core_memtest.sv
// tb_mgmt_core_memtest: directed bench with SPI flash model, code monitor and protocol checker
module tb_mgmt_core_memtest;
  logic clk = 1'b0;
  logic rstn = 1'b0, rstn_f = 1'b0;
  logic gpio, gpio_f;
  logic [127:0] la, la_f;
  logic [31:0] stream = 32'h78563412;
  int fcnt = 0;
  logic [63:0] fbits = '0;
  int fr_n;
  int fr_c [4];
  logic [63:0] fr_b [4];
  logic [95:0] seq;
  int nseq, run, hold_min, viol = 0;
  logic [15:0] prev_c;
  logic last_do;
  logic [31:0] w0_short, w1_short, w15_word;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mgmt_core_memtest_if fl();
  mgmt_core_memtest_if ff();
  assign fl.flash_io1_di = (fcnt >= 33 && fcnt <= 64) ? stream[5'(64 - fcnt)] : 1'b0;
  assign ff.flash_io1_di = 1'b1;
  mgmt_core_memtest dut (
    .core_clk(clk), .core_rstn(rstn), .gpio_out_pad(gpio), .la_output(la), .spi(fl),
    .mprj_dat_i(32'h0), .mprj_ack_i(1'b0), .hk_dat_i(32'h0), .hk_ack_i(1'b0)
  );
  mgmt_core_memtest #(.FAULT_WORD(3)) dut_f (
    .core_clk(clk), .core_rstn(rstn_f), .gpio_out_pad(gpio_f), .la_output(la_f), .spi(ff),
    .mprj_dat_i(32'h0), .mprj_ack_i(1'b0), .hk_dat_i(32'h0), .hk_ack_i(1'b0)
  );
  always @(posedge fl.flash_clk)
    if (!fl.flash_csb) begin
      fbits = {fbits[62:0], fl.flash_io0_do};
      fcnt = fcnt + 1;
    end
  always @(posedge fl.flash_csb) begin
    if (fcnt != 0 && fr_n < 4) begin
      fr_c[fr_n] = fcnt;
      fr_b[fr_n] = fbits;
      fr_n = fr_n + 1;
    end
    fcnt = 0;
    fbits = '0;
  end
  always @(negedge clk) begin
    if (fl.flash_clk === 1'b1 && fl.flash_io0_do !== last_do) viol = viol + 1;
    if (fl.flash_clk === 1'b1 && fl.flash_csb !== 1'b0) viol = viol + 1;
    last_do = fl.flash_io0_do;
    if (la[31:16] != prev_c) begin
      if ((prev_c == 16'hAB41 || prev_c == 16'hAB21) && run < hold_min) hold_min = run;
      if (la[31:16] != 16'h0) begin
        seq = {seq[79:0], la[31:16]};
        nseq = nseq + 1;
      end
      if (la[31:16] == 16'hAB41) w15_word = dut.mem[15];
      if (la[31:16] == 16'hAB21) begin
        w0_short = dut.mem[0];
        w1_short = dut.mem[1];
      end
      prev_c = la[31:16];
      run = 1;
    end else run = run + 1;
  end
  task automatic clear_logs();
    fr_n = 0;
    for (int i = 0; i < 4; i++) begin
      fr_c[i] = 0;
      fr_b[i] = '0;
    end
    seq = '0;
    nseq = 0;
    run = 0;
    hold_min = 1000;
    prev_c = la[31:16];
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && gpio !== 1'b1; i++) @(negedge clk);
  endtask
  task automatic check_pass_run(input string tag);
    n_chk++;
    if (gpio !== 1'b1) $display("FAIL %s_gpio: got %b want 1", tag, gpio); else n_pass++;
    n_chk++;
    if (nseq != 6 || seq !== {16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB11})
      $display("FAIL %s_codes: got %0d codes %h want 6 codes a040ab41a020ab21a010ab11", tag, nseq, seq);
    else n_pass++;
    n_chk++;
    if (la[31:0] !== {16'hAB11, 16'd63}) $display("FAIL %s_la_final: got %h want ab11003f", tag, la[31:0]); else n_pass++;
    n_chk++;
    if (fr_n != 2 || fr_c[0] != 8 || fr_b[0][7:0] !== 8'hAB)
      $display("FAIL %s_wake: got frames=%0d bits=%0d cmd=%h want 2 frames, 8 bits, ab", tag, fr_n, fr_c[0], fr_b[0][7:0]);
    else n_pass++;
    n_chk++;
    if (fr_c[1] != 64 || fr_b[1][63:32] !== 32'h03000000)
      $display("FAIL %s_read_cmd: got bits=%0d cmd=%h want 64 bits, 03000000", tag, fr_c[1], fr_b[1][63:32]);
    else n_pass++;
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    rstn_f = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (la !== 128'h0) $display("FAIL reset_la: got %h want 0", la); else n_pass++;
    n_chk++;
    if (gpio !== 1'b0) $display("FAIL reset_gpio: got %b want 0", gpio); else n_pass++;
    n_chk++;
    if ({fl.flash_csb, fl.flash_clk, fl.flash_io0_do, fl.flash_io0_oeb} !== 4'b1000)
      $display("FAIL reset_spi: got %b want 1000", {fl.flash_csb, fl.flash_clk, fl.flash_io0_do, fl.flash_io0_oeb});
    else n_pass++;
    clear_logs();
    rstn = 1'b1;
    rstn_f = 1'b1;
  endtask
  task automatic test_nominal();
    wait_done(5000);
    check_pass_run("nominal");
    n_chk++;
    if (dut.u_rd.seed !== 32'h12345678) $display("FAIL nominal_seed: got %h want 12345678", dut.u_rd.seed); else n_pass++;
    n_chk++;
    if (w15_word !== 32'h12345687) $display("FAIL word_slot15: got %h want 12345687", w15_word); else n_pass++;
    n_chk++;
    if (w0_short !== 32'h56795678) $display("FAIL short_word0: got %h want 56795678", w0_short); else n_pass++;
    n_chk++;
    if (w1_short !== 32'h567B567A) $display("FAIL short_word1: got %h want 567b567a", w1_short); else n_pass++;
    n_chk++;
    if (dut.mem[0] !== 32'h7B7A7978) $display("FAIL byte_word0: got %h want 7b7a7978", dut.mem[0]); else n_pass++;
    n_chk++;
    if (dut.mem[1] !== 32'h7F7E7D7C) $display("FAIL byte_word1: got %h want 7f7e7d7c", dut.mem[1]); else n_pass++;
    n_chk++;
    if (hold_min < 2) $display("FAIL pass_hold: got %0d cycles want >=2", hold_min); else n_pass++;
  endtask
  task automatic test_fault();
    for (int i = 0; i < 3000 && la_f[31:16] !== 16'hAB40; i++) @(negedge clk);
    n_chk++;
    if (la_f[31:0] !== {16'hAB40, 16'd3}) $display("FAIL fault_code: got %h want ab400003", la_f[31:0]); else n_pass++;
    repeat (200) @(negedge clk);
    n_chk++;
    if (la_f !== {96'h0, 16'hAB40, 16'd3} || gpio_f !== 1'b0 || ff.flash_csb !== 1'b1)
      $display("FAIL fault_halt: got la=%h gpio=%b csb=%b want ab400003 0 1", la_f[31:0], gpio_f, ff.flash_csb);
    else n_pass++;
  endtask
  task automatic test_blank();
    stream = 32'hFFFFFFFF;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rstn = 1'b1;
    wait_done(50000);
    check_pass_run("blank");
    n_chk++;
    if (dut.u_rd.seed !== 32'hFFFFFFFF) $display("FAIL blank_seed: got %h want ffffffff", dut.u_rd.seed); else n_pass++;
    n_chk++;
    if (dut.mem[0] !== 32'h020100FF) $display("FAIL blank_byte_word0: got %h want 020100ff", dut.mem[0]); else n_pass++;
  endtask
  task automatic test_reset_mid();
    stream = 32'h78563412;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rstn = 1'b1;
    for (int i = 0; i < 3000 && la[31:16] !== 16'hA020; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_chk++;
    if (la[31:16] !== 16'hA020) $display("FAIL mid_in_short: got %h want a020", la[31:16]); else n_pass++;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (la !== 128'h0 || gpio !== 1'b0 || fl.flash_csb !== 1'b1 || fl.flash_clk !== 1'b0)
      $display("FAIL mid_reset_vals: got la=%h gpio=%b csb=%b fclk=%b want 0 0 1 0", la[31:0], gpio, fl.flash_csb, fl.flash_clk);
    else n_pass++;
    clear_logs();
    @(negedge clk);
    rstn = 1'b1;
    wait_done(5000);
    check_pass_run("restart");
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_fault();
    test_blank();
    test_reset_mid();
    n_chk++;
    if (viol != 0) $display("FAIL spi_protocol: got %0d violations want 0", viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
